// File: rtl/hazard_pkg.sv
// Shared types for the ID/EX hazard controller: forwarding selects, FSM states
// and the shadow-pipeline stage record.
package hazard_pkg;

   // Shadow rd is stored at this fixed width; REG_ADDR_W must not exceed it.
   localparam int RD_MAX_W = 8;

   typedef logic [RD_MAX_W-1:0] shadow_rd_t;

   typedef enum logic [1:0] {
      FWD_RF    = 2'b00,
      FWD_EXMEM = 2'b01,
      FWD_MEMWB = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } hz_state_t;

   typedef struct packed {
      logic       valid;
      shadow_rd_t rd;
      logic       wen;
      logic       mem_read;
   } shadow_stage_t;

   function automatic logic rd_hit(input shadow_stage_t s, input shadow_rd_t r);
      return s.valid && s.wen && (s.rd == r);
   endfunction

endpackage

// File: rtl/hazard_fwd_mux.sv
// Forwarding select for one ALU source operand: the nearest producing stage wins,
// and a load still in EX/MEM cannot forward.
module hazard_fwd_mux
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 3
) (
   input  logic [REG_ADDR_W-1:0] src,
   input  shadow_stage_t         ex_mem,
   input  shadow_stage_t         mem_wb,
   output logic [1:0]            sel
);

   shadow_rd_t src_ext;
   fwd_sel_t   sel_e;
   logic       unused_mem_read;

   assign src_ext         = shadow_rd_t'(src);
   assign unused_mem_read = mem_wb.mem_read;

   always_comb begin
      sel_e = FWD_RF;
      if (rd_hit(ex_mem, src_ext) && !ex_mem.mem_read)
         sel_e = FWD_EXMEM;
      else if (rd_hit(mem_wb, src_ext))
         sel_e = FWD_MEMWB;
   end

   assign sel = sel_e;

endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX hazard controller: load-use stall, branch flush and operand forwarding.
// Define HAZARD_STATS_EN to build the saturating stall/flush statistics counters.
module id_ex_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W   = 3,
   parameter int FLUSH_CYCLES = 2,
   parameter int STAT_W       = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_rf_write_en,
   input  logic                  id_mem_read,
   input  logic                  ex_branch_taken,
   input  logic                  mem_stall,
   output logic                  stall_pc,
   output logic                  stall_if_id,
   output logic                  bubble_id_ex,
   output logic                  flush_if_id,
   output logic [1:0]            fwd_sel_a,
   output logic [1:0]            fwd_sel_b,
   output logic [STAT_W-1:0]     load_stall_cnt,
   output logic [STAT_W-1:0]     flush_cnt
);

   localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

   shadow_stage_t ex_s, mem_s, wb_s, ex_next;
   hz_state_t     state;
   logic [2:0]    flush_ctr;
   logic          hit_rs1, hit_rs2, load_hazard;
   logic [1:0]    sel_a, sel_b;
   logic          unused_wb;

   assign hit_rs1 = id_valid && id_uses_rs1 && ex_s.valid && ex_s.wen && ex_s.mem_read
                    && (shadow_rd_t'(id_rs1) == ex_s.rd);
   assign hit_rs2 = id_valid && id_uses_rs2 && ex_s.valid && ex_s.wen && ex_s.mem_read
                    && (shadow_rd_t'(id_rs2) == ex_s.rd);
   assign load_hazard = hit_rs1 || hit_rs2;

   // Reset masks every control; mem_stall freezes everything ahead of branch or load handling.
   always_comb begin
      stall_pc     = 1'b0;
      stall_if_id  = 1'b0;
      bubble_id_ex = 1'b0;
      flush_if_id  = 1'b0;
      if (!rst) begin
         if (mem_stall) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
         end else if (state == FLUSH || ex_branch_taken) begin
            flush_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
         end else if (load_hazard) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
         end
      end
   end

   always_comb begin
      ex_next = '0;
      if (!bubble_id_ex)
         ex_next = '{valid: id_valid, rd: shadow_rd_t'(id_rd),
                     wen: id_rf_write_en, mem_read: id_mem_read};
   end

   // WB entry retires here; the register file write-through covers it, so it never forwards.
   assign unused_wb = ^wb_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_s      <= '0;
         mem_s     <= '0;
         wb_s      <= '0;
         state     <= RUN;
         flush_ctr <= '0;
      end else if (!mem_stall) begin
         ex_s  <= ex_next;
         mem_s <= ex_s;
         wb_s  <= mem_s;
         if (ex_branch_taken) begin
            flush_ctr <= FLUSH_RELOAD;
            state     <= (FLUSH_RELOAD != 3'd0) ? FLUSH : RUN;
         end else if (state == FLUSH) begin
            flush_ctr <= flush_ctr - 3'd1;
            if (flush_ctr == 3'd1)
               state <= RUN;
         end
      end
   end

   hazard_fwd_mux #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
      .src    (id_rs1),
      .ex_mem (ex_s),
      .mem_wb (mem_s),
      .sel    (sel_a)
   );

   hazard_fwd_mux #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
      .src    (id_rs2),
      .ex_mem (ex_s),
      .mem_wb (mem_s),
      .sel    (sel_b)
   );

   assign fwd_sel_a = rst ? 2'b00 : sel_a;
   assign fwd_sel_b = rst ? 2'b00 : sel_b;

`ifdef HAZARD_STATS_EN
   logic              load_stall, branch_act;
   logic [STAT_W-1:0] lsc, fc;

   assign branch_act = !rst && !mem_stall && ex_branch_taken;
   assign load_stall = !rst && !mem_stall && (state == RUN) && !ex_branch_taken && load_hazard;

   always_ff @(posedge clk) begin
      if (rst) begin
         lsc <= '0;
         fc  <= '0;
      end else begin
         if (load_stall && (lsc != '1))
            lsc <= lsc + STAT_W'(1);
         if (branch_act && (fc != '1))
            fc <= fc + STAT_W'(1);
      end
   end

   assign load_stall_cnt = lsc;
   assign flush_cnt      = fc;
`else
   assign load_stall_cnt = '0;
   assign flush_cnt      = '0;
`endif

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Table-driven scoreboard bench for id_ex_hazard_ctrl (FLUSH_CYCLES=2, REG_ADDR_W=3);
// statistics expectations follow HAZARD_STATS_EN.
module tb_id_ex_hazard_ctrl;

   localparam int K_NOP = 0;
   localparam int K_LD  = 1;
   localparam int K_ALU = 2;

`ifdef HAZARD_STATS_EN
   localparam bit STATS_EN = 1'b1;
`else
   localparam bit STATS_EN = 1'b0;
`endif

   typedef struct {
      logic       rst, br, ms;
      logic       valid, u1, u2, wen, mr;
      logic [2:0] rd, rs1, rs2;
      logic [3:0] ctl;
      logic [1:0] fa, fb;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_valid = 1'b0, id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
   logic        id_rf_write_en = 1'b0, id_mem_read = 1'b0;
   logic [2:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
   logic        ex_branch_taken = 1'b0, mem_stall = 1'b0;
   logic        stall_pc, stall_if_id, bubble_id_ex, flush_if_id;
   logic [1:0]  fwd_sel_a, fwd_sel_b;
   logic [15:0] load_stall_cnt, flush_cnt;

   vec_t vecs[$];
   vec_t sb_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   row = 0;
   int   lsc_model = 0;
   int   fc_model = 0;
   bit   stats_known = 1'b0;

   always #5 clk = ~clk;

   id_ex_hazard_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .id_valid        (id_valid),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_uses_rs1     (id_uses_rs1),
      .id_uses_rs2     (id_uses_rs2),
      .id_rd           (id_rd),
      .id_rf_write_en  (id_rf_write_en),
      .id_mem_read     (id_mem_read),
      .ex_branch_taken (ex_branch_taken),
      .mem_stall       (mem_stall),
      .stall_pc        (stall_pc),
      .stall_if_id     (stall_if_id),
      .bubble_id_ex    (bubble_id_ex),
      .flush_if_id     (flush_if_id),
      .fwd_sel_a       (fwd_sel_a),
      .fwd_sel_b       (fwd_sel_b),
      .load_stall_cnt  (load_stall_cnt),
      .flush_cnt       (flush_cnt)
   );

   // ctl packs the expected {stall_pc, stall_if_id, bubble_id_ex, flush_if_id}.
   function automatic vec_t mk(input logic r, input logic b, input logic m, input int kind,
                               input int rd, input int s1, input int s2,
                               input logic [3:0] ctl, input int fa, input int fb);
      vec_t v;
      v.rst   = r;
      v.br    = b;
      v.ms    = m;
      v.valid = (kind != K_NOP);
      v.u1    = (kind != K_NOP);
      v.u2    = (kind == K_ALU);
      v.wen   = (kind != K_NOP);
      v.mr    = (kind == K_LD);
      v.rd    = 3'(rd);
      v.rs1   = 3'(s1);
      v.rs2   = 3'(s2);
      v.ctl   = ctl;
      v.fa    = 2'(fa);
      v.fb    = 2'(fb);
      return v;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL row %0d %s: got %0h expected %0h", row, name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input vec_t v);
      @(posedge clk);
      #1;
      rst             = v.rst;
      ex_branch_taken = v.br;
      mem_stall       = v.ms;
      id_valid        = v.valid;
      id_uses_rs1     = v.u1;
      id_uses_rs2     = v.u2;
      id_rf_write_en  = v.wen;
      id_mem_read     = v.mr;
      id_rd           = v.rd;
      id_rs1          = v.rs1;
      id_rs2          = v.rs2;
      sb_q.push_back(v);
   endtask

   task automatic check_output();
      vec_t e;
      @(negedge clk);
      if (sb_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL row %0d scoreboard: got empty queue expected one entry", row);
         return;
      end
      e = sb_q.pop_front();
      check("stall_pc",     16'(stall_pc),     16'(e.ctl[3]));
      check("stall_if_id",  16'(stall_if_id),  16'(e.ctl[2]));
      check("bubble_id_ex", 16'(bubble_id_ex), 16'(e.ctl[1]));
      check("flush_if_id",  16'(flush_if_id),  16'(e.ctl[0]));
      check("fwd_sel_a",    16'(fwd_sel_a),    16'(e.fa));
      check("fwd_sel_b",    16'(fwd_sel_b),    16'(e.fb));
      if (stats_known) begin
         check("load_stall_cnt", load_stall_cnt, STATS_EN ? 16'(lsc_model) : 16'd0);
         check("flush_cnt",      flush_cnt,      STATS_EN ? 16'(fc_model)  : 16'd0);
      end
      if (e.rst) begin
         lsc_model   = 0;
         fc_model    = 0;
         stats_known = 1'b1;
      end else begin
         if (e.ctl == 4'b1110) lsc_model++;
         if (e.br && !e.ms) fc_model++;
      end
      row++;
   endtask

   task automatic run_vec(input vec_t v);
      apply_stimulus(v);
      check_output();
   endtask

   initial begin
      // Reset with a load in flight, load-use stall, forwarding, branch flushes.
      vecs.push_back(mk(1, 0, 0, K_NOP, 0, 0, 0, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 0, 0, K_LD,  3, 1, 0, 4'b0000, 0, 0));
      vecs.push_back(mk(1, 0, 0, K_ALU, 6, 3, 3, 4'b0000, 0, 0));
      vecs.push_back(mk(1, 0, 0, K_ALU, 6, 3, 3, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 0, 0, K_ALU, 6, 3, 3, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 0, 0, K_LD,  3, 1, 0, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 0, 0, K_ALU, 7, 3, 2, 4'b1110, 0, 0));
      vecs.push_back(mk(0, 0, 0, K_ALU, 7, 3, 2, 4'b0000, 2, 0));
      vecs.push_back(mk(0, 0, 0, K_ALU, 5, 1, 1, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 0, 0, K_ALU, 5, 1, 5, 4'b0000, 0, 1));
      vecs.push_back(mk(0, 0, 0, K_ALU, 2, 5, 1, 4'b0000, 1, 0));
      vecs.push_back(mk(0, 0, 0, K_ALU, 4, 1, 5, 4'b0000, 0, 2));
      vecs.push_back(mk(0, 1, 0, K_NOP, 0, 0, 0, 4'b0011, 0, 0));
      vecs.push_back(mk(0, 0, 0, K_NOP, 0, 0, 0, 4'b0011, 0, 0));
      vecs.push_back(mk(0, 0, 0, K_NOP, 0, 0, 0, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 1, 0, K_NOP, 0, 0, 0, 4'b0011, 0, 0));
      vecs.push_back(mk(0, 1, 0, K_NOP, 0, 0, 0, 4'b0011, 0, 0));
      vecs.push_back(mk(0, 0, 0, K_NOP, 0, 0, 0, 4'b0011, 0, 0));
      vecs.push_back(mk(0, 0, 0, K_NOP, 0, 0, 0, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 0, 0, K_LD,  3, 1, 0, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 1, 0, K_ALU, 6, 3, 1, 4'b0011, 0, 0));
      vecs.push_back(mk(0, 0, 0, K_ALU, 6, 3, 1, 4'b0011, 2, 0));
      vecs.push_back(mk(0, 0, 0, K_NOP, 0, 0, 0, 4'b0000, 0, 0));

      foreach (vecs[i]) run_vec(vecs[i]);

      // mem_stall for three cycles inside FLUSH freezes the counter; one flush cycle remains.
      run_vec(mk(0, 1, 0, K_NOP, 0, 0, 0, 4'b0011, 0, 0));
      for (int i = 0; i < 3; i++)
         run_vec(mk(0, 0, 1, K_NOP, 0, 0, 0, 4'b1100, 0, 0));
      run_vec(mk(0, 0, 0, K_NOP, 0, 0, 0, 4'b0011, 0, 0));
      run_vec(mk(0, 0, 0, K_NOP, 0, 0, 0, 4'b0000, 0, 0));

      // A branch coinciding with mem_stall is dropped, not deferred.
      run_vec(mk(0, 1, 1, K_NOP, 0, 0, 0, 4'b1100, 0, 0));
      run_vec(mk(0, 0, 0, K_NOP, 0, 0, 0, 4'b0000, 0, 0));
      run_vec(mk(0, 0, 0, K_NOP, 0, 0, 0, 4'b0000, 0, 0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
